// File: rtl/multi_pkg.sv
// Shared constants for the product display: segment patterns, FSM encodings,
// datapath widths and the committed-display payload.
package multi_pkg;

    localparam int unsigned PROD_W      = 5;
    localparam int unsigned MAG_W       = 5;
    localparam int unsigned BCD_W       = 4;
    localparam int unsigned SEG_W       = 7;
    localparam int unsigned AN_W        = 4;
    localparam int unsigned DIGIT_IDX_W = 2;
    localparam int unsigned REFRESH_W   = 20;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_CONV = 1'b1;

    // Active-low patterns, bit order gfedcba
    localparam logic [SEG_W-1:0] SEG_0     = 7'b1000000;
    localparam logic [SEG_W-1:0] SEG_1     = 7'b1111001;
    localparam logic [SEG_W-1:0] SEG_2     = 7'b0100100;
    localparam logic [SEG_W-1:0] SEG_3     = 7'b0110000;
    localparam logic [SEG_W-1:0] SEG_4     = 7'b0011001;
    localparam logic [SEG_W-1:0] SEG_5     = 7'b0010010;
    localparam logic [SEG_W-1:0] SEG_6     = 7'b0000010;
    localparam logic [SEG_W-1:0] SEG_7     = 7'b1111000;
    localparam logic [SEG_W-1:0] SEG_8     = 7'b0000000;
    localparam logic [SEG_W-1:0] SEG_9     = 7'b0010000;
    localparam logic [SEG_W-1:0] SEG_MINUS = 7'b0111111;
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;

    typedef struct packed {
        logic             sign;
        logic [BCD_W-1:0] tens;
        logic [BCD_W-1:0] units;
    } disp_t;

endpackage

// File: rtl/product_display_if.sv
// Product handshake and display drive bundle between the multiplier side and the display block.
interface product_display_if;
    import multi_pkg::*;

    logic              prod_valid;
    logic [PROD_W-1:0] prod;
    logic              ready;
    logic [SEG_W-1:0]  seg;
    logic [AN_W-1:0]   an;

    modport master (output prod_valid, prod, input ready, seg, an);
    modport slave  (input prod_valid, prod, output ready, seg, an);

endinterface

// File: rtl/product_display_seg7_decode.sv
// Combinational 7-segment decoder: minus overrides blank, blank overrides the digit code.
module seg7_decode
    import multi_pkg::*;
(
    input  logic [BCD_W-1:0] code,
    input  logic             blank,
    input  logic             minus,
    output logic [SEG_W-1:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        if (minus) begin
            seg = SEG_MINUS;
        end else if (!blank) begin
            case (code)
                4'd0:    seg = SEG_0;
                4'd1:    seg = SEG_1;
                4'd2:    seg = SEG_2;
                4'd3:    seg = SEG_3;
                4'd4:    seg = SEG_4;
                4'd5:    seg = SEG_5;
                4'd6:    seg = SEG_6;
                4'd7:    seg = SEG_7;
                4'd8:    seg = SEG_8;
                4'd9:    seg = SEG_9;
                default: seg = SEG_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/product_display.sv
// Signed 5-bit product to multiplexed 4-digit 7-segment display via repeated-subtract BCD.
// Optional macro PRODUCT_DISPLAY_LZB_EN blanks a zero tens digit and moves '-' next to the units.
module product_display
    import multi_pkg::*;
#(
    parameter int unsigned REFRESH_DIV = 100000
) (
    input logic               clk,
    input logic               rst,
    product_display_if.slave  bus
);

    logic [0:0]             state, state_nxt;
    logic                   sign, sign_nxt;
    logic [MAG_W-1:0]       mag, mag_nxt;
    logic [BCD_W-1:0]       tens, tens_nxt;
    disp_t                  disp, disp_nxt;
    logic                   accept;

    logic [REFRESH_W-1:0]   refresh;
    logic [DIGIT_IDX_W-1:0] scan_idx;
    logic [AN_W-1:0]        an_onehot;

    logic [BCD_W-1:0]       dec_code;
    logic                   dec_blank;
    logic                   dec_minus;
    logic [SEG_W-1:0]       dec_seg;

    // Handshake and scan outputs are forced inactive while reset is held
    assign bus.ready = (state == ST_IDLE) && !rst;
    assign accept    = bus.prod_valid && bus.ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            sign  <= 1'b0;
            mag   <= '0;
            tens  <= '0;
            disp  <= '0;
        end else begin
            state <= state_nxt;
            sign  <= sign_nxt;
            mag   <= mag_nxt;
            tens  <= tens_nxt;
            disp  <= disp_nxt;
        end
    end

    // Capture on accept, then peel off tens; display updates only on the final step
    always_comb begin
        state_nxt = state;
        sign_nxt  = sign;
        mag_nxt   = mag;
        tens_nxt  = tens;
        disp_nxt  = disp;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_nxt = ST_CONV;
                    sign_nxt  = bus.prod[PROD_W-1];
                    mag_nxt   = bus.prod[PROD_W-1] ? MAG_W'(~bus.prod + 5'd1) : MAG_W'(bus.prod);
                    tens_nxt  = '0;
                end
            end
            ST_CONV: begin
                if (mag >= MAG_W'(10)) begin
                    mag_nxt  = mag - MAG_W'(10);
                    tens_nxt = tens + BCD_W'(1);
                end else begin
                    disp_nxt.sign  = sign && ((mag != '0) || (tens != '0));
                    disp_nxt.tens  = tens;
                    disp_nxt.units = mag[BCD_W-1:0];
                    state_nxt      = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            refresh  <= '0;
            scan_idx <= '0;
        end else if (refresh == REFRESH_W'(REFRESH_DIV - 1)) begin
            refresh  <= '0;
            scan_idx <= scan_idx + DIGIT_IDX_W'(1);
        end else begin
            refresh  <= refresh + REFRESH_W'(1);
        end
    end

    // Per-digit content selection for the currently scanned position
    always_comb begin
        dec_code  = '0;
        dec_blank = 1'b1;
        dec_minus = 1'b0;
        case (scan_idx)
            2'd0: begin
                dec_code  = disp.units;
                dec_blank = 1'b0;
            end
            2'd1: begin
`ifdef PRODUCT_DISPLAY_LZB_EN
                if (disp.tens == '0) begin
                    dec_minus = disp.sign;
                end else begin
                    dec_code  = disp.tens;
                    dec_blank = 1'b0;
                end
`else
                dec_code  = disp.tens;
                dec_blank = 1'b0;
`endif
            end
            2'd3: begin
`ifdef PRODUCT_DISPLAY_LZB_EN
                dec_minus = disp.sign && (disp.tens != '0);
`else
                dec_minus = disp.sign;
`endif
            end
            default: dec_blank = 1'b1;
        endcase
    end

    seg7_decode u_seg7_decode (
        .code  (dec_code),
        .blank (dec_blank),
        .minus (dec_minus),
        .seg   (dec_seg)
    );

    assign an_onehot = AN_W'(4'b0001 << scan_idx);
    assign bus.an    = rst ? {AN_W{1'b1}} : ~an_onehot;
    assign bus.seg   = rst ? SEG_BLANK : dec_seg;

endmodule

// File: tb/tb_product_display.sv
// Scoreboard bench for product_display: a driver queues expected display values on accept,
// a negedge monitor checks scan/segments every cycle and pops on each commit.
module tb_product_display;

    localparam int REFRESH_DIV = 4;

    localparam logic [6:0] MINUS = 7'b0111111;
    localparam logic [6:0] BLANK = 7'b1111111;

    typedef struct {
        int neg;
        int tens;
        int units;
        int lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;
    exp_t sb_q[$];

    product_display_if bus();

    product_display #(.REFRESH_DIV(REFRESH_DIV)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] digit_pat(input int d);
        logic [6:0] pats [0:9];
        pats[0] = 7'b1000000; pats[1] = 7'b1111001; pats[2] = 7'b0100100;
        pats[3] = 7'b0110000; pats[4] = 7'b0011001; pats[5] = 7'b0010010;
        pats[6] = 7'b0000010; pats[7] = 7'b1111000; pats[8] = 7'b0000000;
        pats[9] = 7'b0010000;
        return pats[d];
    endfunction

    function automatic logic [6:0] exp_seg(input int idx, input exp_t v);
        case (idx)
            0: return digit_pat(v.units);
`ifdef PRODUCT_DISPLAY_LZB_EN
            1: return (v.tens == 0) ? (v.neg != 0 ? MINUS : BLANK) : digit_pat(v.tens);
            3: return (v.neg != 0 && v.tens != 0) ? MINUS : BLANK;
`else
            1: return digit_pat(v.tens);
            3: return (v.neg != 0) ? MINUS : BLANK;
`endif
            default: return BLANK;
        endcase
    endfunction

    function automatic exp_t model(input logic [4:0] p);
        exp_t e;
        int   val, a;
        val     = int'($signed(p));
        a       = (val < 0) ? -val : val;
        e.neg   = (val < 0) ? 1 : 0;
        e.tens  = a / 10;
        e.units = a % 10;
        e.lat   = (a >= 10) ? 2 : 1;
        return e;
    endfunction

    task automatic drive(input logic v, input logic [4:0] p, input logic r);
        @(posedge clk);
        #1;
        rst            = r;
        bus.prod_valid = v;
        bus.prod       = p;
        #0;
        if (v && bus.ready) sb_q.push_back(model(p));
    endtask

    // Monitor: scan position model from cycle count, display model updated at each commit
    initial begin : monitor
        exp_t shown;
        int   cyc;
        int   low;
        int   idx;
        logic [6:0] want;
        shown = '{0, 0, 0, 0};
        cyc   = 0;
        low   = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                checks++;
                if (bus.an !== 4'b1111 || bus.seg !== BLANK || bus.ready !== 1'b0) begin
                    failures++;
                    $display("FAIL reset_outputs: an=%b seg=%b ready=%b required an=1111 seg=1111111 ready=0",
                             bus.an, bus.seg, bus.ready);
                end
                shown = '{0, 0, 0, 0};
                sb_q.delete();
                cyc = 0;
                low = 0;
            end else begin
                if (bus.ready !== 1'b1) begin
                    low++;
                    if (low > 2) begin
                        checks++;
                        failures++;
                        $display("FAIL ready_low_too_long: low_cycles=%0d required<=2", low);
                    end
                end else if (low > 0) begin
                    checks++;
                    if (sb_q.size() == 0) begin
                        failures++;
                        $display("FAIL unexpected_commit: queue empty after %0d busy cycles", low);
                    end else begin
                        shown = sb_q.pop_front();
                        if (low != shown.lat) begin
                            failures++;
                            $display("FAIL commit_latency: got=%0d required=%0d", low, shown.lat);
                        end
                    end
                    low = 0;
                end
                idx = (cyc / REFRESH_DIV) % 4;
                checks++;
                if (bus.an !== ~(4'b0001 << idx)) begin
                    failures++;
                    $display("FAIL an_scan: cyc=%0d an=%b required=%b", cyc, bus.an, ~(4'b0001 << idx));
                end
                want = exp_seg(idx, shown);
                checks++;
                if (bus.seg !== want) begin
                    failures++;
                    $display("FAIL seg_digit%0d: cyc=%0d seg=%b required=%b (neg=%0d tens=%0d units=%0d)",
                             idx, cyc, bus.seg, want, shown.neg, shown.tens, shown.units);
                end
                cyc++;
            end
        end
    end

    initial begin : watchdog
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : driver
        logic [4:0] p;
        rst            = 1'b1;
        bus.prod_valid = 1'b0;
        bus.prod       = '0;
        repeat (3) drive(1'b0, 5'd0, 1'b1);
        repeat (20) drive(1'b0, 5'd0, 1'b0);

        // +6, -16, -9, 0, +15: single-cycle valid, then let several scan rounds pass
        drive(1'b1, 5'b00110, 1'b0);
        repeat (20) drive(1'b0, 5'd0, 1'b0);
        drive(1'b1, 5'b10000, 1'b0);
        repeat (20) drive(1'b0, 5'd0, 1'b0);
        drive(1'b1, 5'b10111, 1'b0);
        repeat (20) drive(1'b0, 5'd0, 1'b0);
        drive(1'b1, 5'b00000, 1'b0);
        repeat (20) drive(1'b0, 5'd0, 1'b0);
        drive(1'b1, 5'b01111, 1'b0);
        repeat (20) drive(1'b0, 5'd0, 1'b0);

        // Valid held through CONV with a different second value
        drive(1'b1, 5'b11001, 1'b0);
        drive(1'b1, 5'b00011, 1'b0);
        drive(1'b1, 5'b00011, 1'b0);
        repeat (20) drive(1'b0, 5'd0, 1'b0);

        // Reset on the cycle after accepting -16 aborts it
        drive(1'b1, 5'b10000, 1'b0);
        drive(1'b0, 5'd0, 1'b1);
        drive(1'b0, 5'd0, 1'b0);
        repeat (20) drive(1'b0, 5'd0, 1'b0);

        for (int i = 0; i < 600; i++) begin
            p = 5'($urandom_range(0, 31));
            if ($urandom_range(0, 99) < 2) begin
                drive(1'($urandom_range(0, 1)), p, 1'b1);
            end else begin
                drive(1'($urandom_range(0, 99) < 40), p, 1'b0);
            end
        end
        repeat (20) drive(1'b0, 5'd0, 1'b0);

        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL drain: pending=%0d required=0", sb_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/product_display.md
PRODUCT_DISPLAY -- requirements
Module: product_display

Interface
REQ-001 SHALL have parameter REFRESH_DIV, default 100000, clock cycles each digit stays enabled; legal range 2..2^20.
REQ-002 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-004 SHALL have port prod_valid, input, 1, product on prod is valid this cycle.
REQ-005 SHALL have port prod, input, 5, signed two's-complement product from the multiplier stage.
REQ-006 SHALL have port ready, output, 1, block accepts a new product this cycle.
REQ-007 SHALL have port seg, output, 7, active-low segments, seg[0]=a .. seg[6]=g.
REQ-008 SHALL have port an, output, 4, active-low digit enables, an[0]=rightmost digit.

Function
REQ-009 SHALL accept a product only on a cycle with prod_valid=1 and ready=1; prod_valid while ready=0 is ignored, not queued.
REQ-010 SHALL use states IDLE (ready=1) and CONV (ready=0); accept moves IDLE->CONV on the same edge.
REQ-011 On accept SHALL capture sign=prod[4] and mag=|prod| as 5-bit unsigned, -16 giving 16; tens counter cleared.
REQ-012 In CONV, per cycle: if mag>=10, mag-=10 and tens+=1; else commit sign, tens, units=mag to display registers and return to IDLE.
REQ-013 Latency accept-edge to commit-edge SHALL be 1 cycle for |prod|<10 and 2 cycles for |prod|>=10.
REQ-014 Display registers SHALL hold the previous value until commit; no partial value is ever shown.
REQ-015 Refresh counter SHALL count 0..REFRESH_DIV-1 and wrap; digit index advances 0->1->2->3->0 at each wrap.
REQ-016 an SHALL be one-hot-low on the current digit index; seg SHALL be the pattern for that digit in the same cycle.
REQ-017 Digit 0 SHALL show units, digit 1 tens, digit 2 blank, digit 3 '-' if sign=1 and mag nonzero, else blank.
REQ-018 Value 0 SHALL display as positive; -0 cannot occur.
REQ-019 Patterns (gfedcba, active low): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, '-'=0111111, blank=1111111.
REQ-020 Scanning SHALL continue uninterrupted during CONV and is independent of accept traffic.

Reset
REQ-021 While rst=1: state IDLE, ready=0, an=1111, seg=1111111, refresh counter 0, digit index 0, display registers sign=0 tens=0 units=0.
REQ-022 First cycle after rst deasserts SHALL have ready=1 and an=1110.
REQ-023 rst during CONV SHALL abort the conversion and discard the captured product.

Configuration
REQ-024 Macro PRODUCT_DISPLAY_LZB_EN: defined -> digit 1 blank when tens=0 and '-' moves to digit 1 for negatives; undefined -> digit 1 shows '0' and '-' stays on digit 3.

Structure
REQ-025 Shared package multi_pkg SHALL hold segment-pattern constants, state encodings and digit-index width.
REQ-026 Combinational sub-module seg7_decode SHALL map a 4-bit code plus blank/minus selects to the 7-bit pattern.

Verification (REFRESH_DIV=4)
REQ-027 rst 3 cycles then release -> ready=1, an cycles 1110,1101,1011,0111 every 4 cycles, digits show blank,blank,0,0 (LZB off: '0' on digit 1).
REQ-028 prod=5'b00110 (+6), valid 1 cycle -> ready low 1 cycle, then digit 0 seg=0000010, digit 3 blank.
REQ-029 prod=5'b10000 (-16) -> ready low 2 cycles, digit 1 seg=1111001, digit 0 seg=0000010, digit 3 seg=0111111.
REQ-030 prod=5'b10111 (-9) with LZB_EN defined -> digit 0=0010000, digit 1=0111111, digits 2,3 blank.
REQ-031 valid held during CONV with a different value -> second value ignored, first value displayed.
REQ-032 rst asserted on the cycle after accepting -16 -> display returns to 0, no '-' shown, ready=1 after release.
